// File: rtl/diff_clk_fwd.sv
// Differential clock forwarder.
// Generates a divided clock from clk with a programmable half-period
// (div + 1 cycles), starts and stops it without glitches or runt phases,
// and drives it off-chip through a single differential output buffer fed
// directly from a flop.

module diff_clk_fwd #(
    parameter int    DIV_W      = 8,
    parameter int    DIV_RST    = 1,
    parameter string IOSTANDARD = "DEFAULT"
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic             div_load,
    output logic             clk_out_p,
    output logic             clk_out_n,
    output logic             running
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] DIV_RST_V = DIV_W'(DIV_RST);
    localparam logic [DIV_W-1:0] CNT_ONE   = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0] CNT_ZERO  = {DIV_W{1'b0}};

    state_t           state;
    logic             out_q;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_act;
    logic [DIV_W-1:0] div_pend;
    logic             pend_vld;
    logic             boundary_s;

    // End of the current half-period: cnt has reached the active divider.
    always_comb begin
        boundary_s = (cnt == div_act);
    end

    // Clock generation FSM with pending-divider handling; all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            out_q    <= 1'b0;
            running  <= 1'b0;
            cnt      <= CNT_ZERO;
            div_act  <= DIV_RST_V;
            div_pend <= DIV_RST_V;
            pend_vld <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt   <= CNT_ZERO;
                    out_q <= 1'b0;
                    if (pend_vld) begin
                        div_act  <= div_pend;
                        pend_vld <= 1'b0;
                    end
                    if (en) begin
                        // Start with a full high phase; a same-edge load is used at once.
                        state   <= RUN;
                        running <= 1'b1;
                        out_q   <= 1'b1;
                        if (div_load) begin
                            div_act <= div;
                        end
                    end else begin
                        running <= 1'b0;
                    end
                end
                RUN: begin
                    if (!en && !out_q) begin
                        // Stopping in a low phase only stretches that low phase.
                        state   <= IDLE;
                        running <= 1'b0;
                        cnt     <= CNT_ZERO;
                        out_q   <= 1'b0;
                    end else if (boundary_s) begin
                        cnt   <= CNT_ZERO;
                        out_q <= ~out_q;
                        if (pend_vld) begin
                            div_act  <= div_pend;
                            pend_vld <= 1'b0;
                        end
                        if (!en) begin
                            // High phase just completed and en is gone: stop now.
                            state   <= IDLE;
                            running <= 1'b0;
                        end else begin
                            state <= RUN;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                        if (!en) begin
                            state <= STOP;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                STOP: begin
                    // Finish the high phase regardless of en, then park in IDLE.
                    if (boundary_s) begin
                        state   <= IDLE;
                        running <= 1'b0;
                        out_q   <= 1'b0;
                        cnt     <= CNT_ZERO;
                        if (pend_vld) begin
                            div_act  <= div_pend;
                            pend_vld <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                    out_q   <= 1'b0;
                    cnt     <= CNT_ZERO;
                end
            endcase
            // A new divider request overrides any clear above and waits for the next boundary.
            if (div_load) begin
                div_pend <= div;
                pend_vld <= 1'b1;
            end
        end
    end

    OBUFDS #(
        .IOSTANDARD(IOSTANDARD)
    ) u_obufds (
        .O  (clk_out_p),
        .OB (clk_out_n),
        .I  (out_q)
    );

endmodule

// Behavioural model of the vendor differential output buffer, used where
// the vendor library is not available.
module OBUFDS #(
    parameter string IOSTANDARD = "DEFAULT"
) (
    output logic O,
    output logic OB,
    input  logic I
);

    // Non-inverting and inverting legs of the pad pair.
    always_comb begin
        O  = I;
        OB = ~I;
    end

endmodule

// File: tb/tb_diff_clk_fwd.sv
// Directed testbench for diff_clk_fwd: start/stop behaviour, divider
// changes, div=0 operation and asynchronous reset.

module tb_diff_clk_fwd;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] div;
    logic       div_load;
    logic       clk_out_p;
    logic       clk_out_n;
    logic       running;

    int checks;
    int failures;

    diff_clk_fwd #(
        .DIV_W      (8),
        .DIV_RST    (1),
        .IOSTANDARD ("DEFAULT")
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .div       (div),
        .div_load  (div_load),
        .clk_out_p (clk_out_p),
        .clk_out_n (clk_out_n),
        .running   (running)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic exp_p, input logic exp_run);
        chk({tag, ".p"}, clk_out_p, exp_p);
        chk({tag, ".n"}, clk_out_n, ~exp_p);
        chk({tag, ".running"}, running, exp_run);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One edge per character of pat; expected clk_out_p = char, running = 1.
    task automatic run_seq(input string tag, input string pat);
        for (int i = 0; i < pat.len(); i++) begin
            tick();
            expect_out($sformatf("%s[%0d]", tag, i), (pat[i] == "1"), 1'b1);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        div      = 8'd0;
        div_load = 1'b0;

        // Reset state, no clock edge needed.
        #2;
        expect_out("reset", 1'b0, 1'b0);
        tick();
        tick();
        #3 rst_n = 1'b1;
        tick();
        expect_out("idle_after_release", 1'b0, 1'b0);

        // DIV_RST=1: period 4, starting with high on the first edge.
        en = 1'b1;
        run_seq("div_rst", "11001100");
        en = 1'b0;
        tick();
        expect_out("div_rst_stop", 1'b0, 1'b0);

        // div=0 loaded in IDLE: toggle every edge.
        div = 8'd0;
        div_load = 1'b1;
        tick();
        div_load = 1'b0;
        tick();
        expect_out("div0_idle", 1'b0, 1'b0);
        en = 1'b1;
        run_seq("div0", "101010");
        en = 1'b0;
        tick();
        expect_out("div0_stop", 1'b0, 1'b0);

        // div=3 loaded together with en, then div=1 loaded mid-high.
        div = 8'd3;
        div_load = 1'b1;
        en = 1'b1;
        run_seq("div3", "111100001");
        div = 8'd1;
        div_load = 1'b1;
        tick();
        expect_out("div3_load_edge", 1'b1, 1'b1);
        div_load = 1'b0;
        run_seq("div3to1", "11001100");
        en = 1'b0;
        tick();
        expect_out("div1_stop_low", 1'b0, 1'b0);

        // div=2, en dropped one cycle into the high phase -> STOP.
        div = 8'd2;
        div_load = 1'b1;
        en = 1'b1;
        tick();
        expect_out("div2_start", 1'b1, 1'b1);
        div_load = 1'b0;
        en = 1'b0;
        run_seq("div2_stop", "11");
        tick();
        expect_out("div2_stop_end", 1'b0, 1'b0);

        // en dropped during low phase, then restart gives a full high phase.
        en = 1'b1;
        run_seq("div2_run", "11100");
        en = 1'b0;
        tick();
        expect_out("div2_low_stop", 1'b0, 1'b0);
        en = 1'b1;
        run_seq("div2_restart", "1110001");

        // STOP ignores a re-asserted en until it has been back to IDLE.
        en = 1'b0;
        tick();
        expect_out("stop_enter", 1'b1, 1'b1);
        en = 1'b1;
        tick();
        expect_out("stop_ignore_en", 1'b1, 1'b1);
        tick();
        expect_out("stop_to_idle", 1'b0, 1'b0);
        tick();
        expect_out("idle_restart", 1'b1, 1'b1);

        // Asynchronous reset mid-high-phase, away from any clock edge.
        #2 rst_n = 1'b0;
        #1;
        expect_out("async_reset", 1'b0, 1'b0);
        #3 rst_n = 1'b1;
        // Divider back to DIV_RST=1 -> period 4 again (en still high).
        run_seq("post_reset", "1100110");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
